// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-outstanding initiator for the sel/wr/addr/wdata/rdata/ready register bus
// Reads follow the slave's ready-drop/recovery handshake; a stalled slave is aborted after TIMEOUT cycles.
module reg_bus_master #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_wr,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  bus_sel,
   output logic                  bus_wr,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_ready
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, REQ, RDATA, WAIT_RDY, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          wr_q;
   logic          timed_out;

   assign cmd_ready = (state == IDLE);
   assign timed_out = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_q      <= 1'b0;
         bus_sel   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wr_q      <= cmd_wr;
                  bus_sel   <= 1'b1;
                  bus_wr    <= cmd_wr;
                  bus_addr  <= cmd_addr;
                  bus_wdata <= cmd_wdata;
                  cnt       <= '0;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (bus_ready) begin
                  if (wr_q) begin
                     bus_sel   <= 1'b0;
                     bus_wr    <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_wr    <= 1'b1;
                     rsp_rdata <= '0;
                     rsp_err   <= 1'b0;
                     state     <= RESP;
                  end else begin
                     state <= RDATA;
                  end
               end else if (timed_out) begin
                  bus_sel   <= 1'b0;
                  bus_wr    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_wr    <= wr_q;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // sel stays high this cycle so the slave can re-raise ready
            RDATA: begin
               rsp_rdata <= bus_rdata;
               bus_sel   <= 1'b0;
               cnt       <= '0;
               state     <= WAIT_RDY;
            end
            WAIT_RDY: begin
               if (bus_ready) begin
                  rsp_valid <= 1'b1;
                  rsp_wr    <= 1'b0;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (timed_out) begin
                  rsp_valid <= 1'b1;
                  rsp_wr    <= wr_q;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
